fc_result_writer: RTL and testbench

- Downstream stage of the 4-core fully-connected data mover.
- Takes the four 32-bit per-lane results and their joint valid, and applies ReLU, a run-time arithmetic right shift and unsigned 8-bit saturation to each lane.
- Packs the four bytes into one 32-bit word and writes it to the output BRAM (port b3) at sequential addresses.
- Has its own idle/run/done control handshake, driven by the same i_run/i_num_cnt as the mover.

---
 rtl/fc_pkg.sv | 25 ++
 rtl/fc_lane_requant.sv | 32 +++
 rtl/fc_result_writer.sv | 155 +++++++++++++++
 tb/tb_fc_result_writer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fc_pkg
//  Description : Shared definitions for the fully-connected data mover and
//                its result writer: FSM state encodings, lane count and the
//                byte position of each lane inside a packed output word.
//  Revision    : 1.0 - initial release
// ============================================================================
package fc_pkg;

    // State encodings shared with the data mover so both blocks report the
    // same status values.
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    localparam int LANES = 4;

    // Lane 0 occupies the most significant byte, lane LANES-1 the least.
    function automatic int lane_lsb(input int lane, input int lane_w);
        return (LANES - 1 - lane) * lane_w;
    endfunction

endpackage : fc_pkg
`default_nettype wire

// File: rtl/fc_lane_requant.sv
`default_nettype none
// ============================================================================
//  Module      : fc_lane_requant
//  Description : Re-quantises one signed lane result to an unsigned byte:
//                ReLU, arithmetic right shift, then saturation to the byte
//                range. Purely combinational.
//  Ports       : i_result - signed lane result
//                i_shift  - right-shift amount
//                o_byte   - requantised byte
//                o_sat    - high when the value was clipped to all-ones
//  Revision    : 1.0 - initial release
// ============================================================================
module fc_lane_requant #(
    parameter int DWIDTH         = 32,
    parameter int OUT_DATA_WIDTH = 8
) (
    input  logic signed [DWIDTH-1:0]         i_result,
    input  logic        [4:0]                i_shift,
    output logic        [OUT_DATA_WIDTH-1:0] o_byte,
    output logic                             o_sat
);

    logic signed [DWIDTH-1:0] w_y;

    // Negative inputs collapse to zero, so w_y is never negative and any set
    // bit above the byte range means the value exceeds the byte maximum.
    assign w_y    = i_result[DWIDTH-1] ? '0 : (i_result >>> i_shift);
    assign o_sat  = |w_y[DWIDTH-1:OUT_DATA_WIDTH];
    assign o_byte = o_sat ? {OUT_DATA_WIDTH{1'b1}} : w_y[OUT_DATA_WIDTH-1:0];

endmodule : fc_lane_requant
`default_nettype wire

// File: rtl/fc_result_writer.sv
`default_nettype none
// ============================================================================
//  Module      : fc_result_writer
//  Description : Downstream stage of the 4-core fully-connected data mover.
//                Requantises the four lane results, packs them into one word
//                and writes it to the output BRAM at sequential addresses.
//                Runs its own idle/run/done handshake.
//  Ports       : clk, reset          - clock, synchronous active-high reset
//                i_run, i_num_cnt,
//                i_shift             - start pulse, word count, shift amount
//                o_idle/o_run/o_done - FSM status (o_done is a 1-cycle pulse)
//                i_valid, i_result_* - joint valid and per-lane results
//                addr_b3/ce_b3/we_b3/
//                d_b3/q_b3           - output BRAM port (q_b3 unused)
//                o_sat_cnt           - lanes clipped in current/last run
//  Revision    : 1.0 - initial release
// ============================================================================
module fc_result_writer #(
    parameter int CNT_BIT        = 31,
    parameter int DWIDTH         = 32,
    parameter int AWIDTH         = 12,
    parameter int OUT_DATA_WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_run,
    input  logic [CNT_BIT-1:0] i_num_cnt,
    input  logic [4:0]         i_shift,
    output logic               o_idle,
    output logic               o_run,
    output logic               o_done,
    input  logic               i_valid,
    input  logic [DWIDTH-1:0]  i_result_0,
    input  logic [DWIDTH-1:0]  i_result_1,
    input  logic [DWIDTH-1:0]  i_result_2,
    input  logic [DWIDTH-1:0]  i_result_3,
    output logic [AWIDTH-1:0]  addr_b3,
    output logic               ce_b3,
    output logic               we_b3,
    output logic [DWIDTH-1:0]  d_b3,
    input  logic [DWIDTH-1:0]  q_b3,
    output logic [CNT_BIT-1:0] o_sat_cnt
);

    import fc_pkg::*;

    localparam logic [CNT_BIT-1:0] c_ONE = CNT_BIT'(1);

    logic [1:0]         r_state;
    logic [CNT_BIT-1:0] r_num_cnt;
    logic [4:0]         r_shift;
    logic [CNT_BIT-1:0] r_wr_cnt;

    logic [DWIDTH-1:0]         w_result [LANES];
    logic [OUT_DATA_WIDTH-1:0] w_byte   [LANES];
    logic [LANES-1:0]          w_sat;
    logic [DWIDTH-1:0]         w_packed;
    logic [2:0]                w_sat_sum;
    logic                      w_accept;
    logic                      w_last;

    // The read port is not needed by a write-only stage.
    logic w_unused_q_b3;
    assign w_unused_q_b3 = ^q_b3;

    assign w_result[0] = i_result_0;
    assign w_result[1] = i_result_1;
    assign w_result[2] = i_result_2;
    assign w_result[3] = i_result_3;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            localparam int c_LSB = lane_lsb(gi, OUT_DATA_WIDTH);

            fc_lane_requant #(
                .DWIDTH         (DWIDTH),
                .OUT_DATA_WIDTH (OUT_DATA_WIDTH)
            ) u_requant (
                .i_result (w_result[gi]),
                .i_shift  (r_shift),
                .o_byte   (w_byte[gi]),
                .o_sat    (w_sat[gi])
            );

            assign w_packed[c_LSB +: OUT_DATA_WIDTH] = w_byte[gi];
        end
    endgenerate

    always_comb begin
        w_sat_sum = '0;
        for (int k = 0; k < LANES; k++) begin
            w_sat_sum = w_sat_sum + {2'b00, w_sat[k]};
        end
    end

    assign w_accept = i_valid && (r_state == S_RUN);
    assign w_last   = (r_wr_cnt == (r_num_cnt - c_ONE));

    assign o_idle = (r_state == S_IDLE);
    assign o_run  = (r_state == S_RUN);
    assign o_done = (r_state == S_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_num_cnt <= '0;
            r_shift   <= '0;
            r_wr_cnt  <= '0;
            addr_b3   <= '0;
            d_b3      <= '0;
            ce_b3     <= 1'b0;
            we_b3     <= 1'b0;
            o_sat_cnt <= '0;
        end else begin
            // Strobes are high only for the cycle following an accept; data
            // and address hold their last values otherwise.
            ce_b3 <= w_accept;
            we_b3 <= w_accept;

            if (w_accept) begin
                d_b3      <= w_packed;
                // Address silently wraps when the run exceeds BRAM depth.
                addr_b3   <= r_wr_cnt[AWIDTH-1:0];
                r_wr_cnt  <= r_wr_cnt + c_ONE;
                o_sat_cnt <= o_sat_cnt + {{(CNT_BIT-3){1'b0}}, w_sat_sum};
            end

            case (r_state)
                S_IDLE: begin
                    if (i_run) begin
                        r_num_cnt <= i_num_cnt;
                        r_shift   <= i_shift;
                        r_wr_cnt  <= '0;
                        o_sat_cnt <= '0;
                        // An empty run still completes the handshake.
                        r_state   <= (i_num_cnt == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_accept && w_last) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule : fc_result_writer
`default_nettype wire

// File: tb/tb_fc_result_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fc_result_writer
//  Description : Scoreboard bench for fc_result_writer. Stimulus pushes the
//                expected BRAM writes into a queue; a monitor pops and
//                compares each time we_b3 is seen. Built with a 2-bit address
//                so the wrap case is reachable.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fc_result_writer;

    localparam int CNT_BIT = 31;
    localparam int DWIDTH  = 32;
    localparam int AWIDTH  = 2;

    logic               clk;
    logic               reset;
    logic               i_run;
    logic [CNT_BIT-1:0] i_num_cnt;
    logic [4:0]         i_shift;
    logic               o_idle;
    logic               o_run;
    logic               o_done;
    logic               i_valid;
    logic [DWIDTH-1:0]  i_result_0;
    logic [DWIDTH-1:0]  i_result_1;
    logic [DWIDTH-1:0]  i_result_2;
    logic [DWIDTH-1:0]  i_result_3;
    logic [AWIDTH-1:0]  addr_b3;
    logic               ce_b3;
    logic               we_b3;
    logic [DWIDTH-1:0]  d_b3;
    logic [DWIDTH-1:0]  q_b3;
    logic [CNT_BIT-1:0] o_sat_cnt;

    fc_result_writer #(
        .CNT_BIT        (CNT_BIT),
        .DWIDTH         (DWIDTH),
        .AWIDTH         (AWIDTH),
        .OUT_DATA_WIDTH (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_run      (i_run),
        .i_num_cnt  (i_num_cnt),
        .i_shift    (i_shift),
        .o_idle     (o_idle),
        .o_run      (o_run),
        .o_done     (o_done),
        .i_valid    (i_valid),
        .i_result_0 (i_result_0),
        .i_result_1 (i_result_1),
        .i_result_2 (i_result_2),
        .i_result_3 (i_result_3),
        .addr_b3    (addr_b3),
        .ce_b3      (ce_b3),
        .we_b3      (we_b3),
        .d_b3       (d_b3),
        .q_b3       (q_b3),
        .o_sat_cnt  (o_sat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AWIDTH-1:0] addr;
        logic [DWIDTH-1:0] data;
        logic              done;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every BRAM write must match the oldest expected write.
    always @(negedge clk) begin
        wr_t e;
        if (we_b3 === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0h data %0h, none expected (t=%0t)", addr_b3, d_b3, $time);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 64'(addr_b3), 64'(e.addr));
                chk("wr_data", 64'(d_b3), 64'(e.data));
                chk("wr_ce", 64'(ce_b3), 64'd1);
                chk("wr_done", 64'(o_done), 64'(e.done));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int num, input int sh);
        i_run     = 1'b1;
        i_num_cnt = CNT_BIT'(num);
        i_shift   = 5'(sh);
        step(1);
        i_run = 1'b0;
    endtask

    task automatic send(input logic [31:0] r0, input logic [31:0] r1,
                        input logic [31:0] r2, input logic [31:0] r3,
                        input logic [31:0] exp_d, input int exp_a, input logic last);
        wr_t e;
        e.addr = AWIDTH'(exp_a);
        e.data = exp_d;
        e.done = last;
        exp_q.push_back(e);
        i_valid    = 1'b1;
        i_result_0 = r0;
        i_result_1 = r1;
        i_result_2 = r2;
        i_result_3 = r3;
        step(1);
        i_valid = 1'b0;
    endtask

    // Valid with data that would produce a write if wrongly accepted.
    task automatic stray_valid();
        i_valid    = 1'b1;
        i_result_0 = 32'h55;
        i_result_1 = 32'h55;
        i_result_2 = 32'h55;
        i_result_3 = 32'h55;
        step(1);
        i_valid = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        i_run      = 1'b0;
        i_num_cnt  = '0;
        i_shift    = '0;
        i_valid    = 1'b0;
        i_result_0 = '0;
        i_result_1 = '0;
        i_result_2 = '0;
        i_result_3 = '0;
        q_b3       = 32'hDEADBEEF;
        step(2);
        reset = 1'b0;

        // Reset state
        chk("rst_idle", 64'(o_idle), 64'd1);
        chk("rst_done", 64'(o_done), 64'd0);
        chk("rst_we", 64'(we_b3), 64'd0);
        chk("rst_sat", 64'(o_sat_cnt), 64'd0);

        // Basic run: 0x100>>1=0x80, 2>>1=1, 0x1FE>>1=0xFF, 0 -> 8001FF00
        start_run(3, 1);
        chk("t1_run", 64'(o_run), 64'd1);
        send(32'h100, 32'h2, 32'h1FE, 32'h0, 32'h8001FF00, 0, 1'b0);
        send(32'h100, 32'h2, 32'h1FE, 32'h0, 32'h8001FF00, 1, 1'b0);
        send(32'h100, 32'h2, 32'h1FE, 32'h0, 32'h8001FF00, 2, 1'b1);
        step(1);
        chk("t1_idle", 64'(o_idle), 64'd1);
        chk("t1_sat", 64'(o_sat_cnt), 64'd0);

        // ReLU and saturation, shift 4: -5->0, 0x10000->clip, 0xFF0->FF, 0x1000->clip
        start_run(1, 4);
        send(32'hFFFFFFFB, 32'h10000, 32'hFF0, 32'h1000, 32'h00FFFFFF, 0, 1'b1);
        step(1);
        chk("t2_sat", 64'(o_sat_cnt), 64'd2);
        step(2);
        chk("t2_sat_hold", 64'(o_sat_cnt), 64'd2);

        // Gapped valids, then stray valids in DONE and IDLE
        start_run(2, 0);
        send(32'h7, 32'h1, 32'h300, 32'hFF, 32'h0701FFFF, 0, 1'b0);
        step(4);
        send(32'h0, 32'h80, 32'h0, 32'h12, 32'h00800012, 1, 1'b1);
        chk("t3_done", 64'(o_done), 64'd1);
        stray_valid();
        chk("t3_idle", 64'(o_idle), 64'd1);
        step(2);
        stray_valid();
        step(2);
        chk("t3_sat", 64'(o_sat_cnt), 64'd1);

        // Zero count
        start_run(0, 0);
        chk("t4_done", 64'(o_done), 64'd1);
        chk("t4_no_we", 64'(we_b3), 64'd0);
        step(1);
        chk("t4_idle", 64'(o_idle), 64'd1);
        chk("t4_done_low", 64'(o_done), 64'd0);

        // Mid-run reset and ignored restart
        start_run(4, 0);
        send(32'h1, 32'h2, 32'h3, 32'h4, 32'h01020304, 0, 1'b0);
        start_run(1, 3);
        chk("t5_still_run", 64'(o_run), 64'd1);
        send(32'h10, 32'h20, 32'h30, 32'h40, 32'h10203040, 1, 1'b0);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("t5_rst_idle", 64'(o_idle), 64'd1);
        chk("t5_rst_done", 64'(o_done), 64'd0);
        chk("t5_rst_addr", 64'(addr_b3), 64'd0);
        chk("t5_rst_data", 64'(d_b3), 64'd0);
        chk("t5_rst_ce", 64'(ce_b3), 64'd0);
        chk("t5_rst_we", 64'(we_b3), 64'd0);
        chk("t5_rst_sat", 64'(o_sat_cnt), 64'd0);
        start_run(1, 0);
        send(32'hAA, 32'hBB, 32'hCC, 32'hDD, 32'hAABBCCDD, 0, 1'b1);
        step(1);

        // Address wrap with a 2-bit address
        start_run(5, 0);
        for (int i = 0; i < 5; i++) begin
            send(32'(i), 32'h0, 32'h0, 32'(8'hF0 + i), {8'(i), 16'h0000, 8'(8'hF0 + i)}, i % 4, (i == 4));
        end
        step(1);
        chk("t6_idle", 64'(o_idle), 64'd1);
        step(2);

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fc_result_writer
`default_nettype wire
